// File: rtl/eq_mon_pkg.sv
// ---------------------------------------------------------------------------
// eq_mon_pkg
// Shared types and helpers for the eq_compare_monitor checker slice.
//   chk_state_t : per-channel consecutive-mismatch state (OK / WARN / ALARM)
//   STREAK_W    : width of the consecutive-mismatch streak counter
//   sat_inc     : saturating increment for counters up to 32 bits wide
// ---------------------------------------------------------------------------
package eq_mon_pkg;

    localparam int unsigned STREAK_W = 8;

    typedef enum logic [1:0] {
        OK    = 2'd0,
        WARN  = 2'd1,
        ALARM = 2'd2
    } chk_state_t;

    // Callers zero-extend their counter to 32 bits and pass the all-ones
    // value of their own width as the ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/eq_compare_monitor_chan.sv
// ---------------------------------------------------------------------------
// eq_chan_checker
// One monitor channel: masked compare, saturating pass/fail counters,
// consecutive-mismatch streak with OK/WARN/ALARM FSM, registered match and
// one-cycle mismatch pulse.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_en, i_clr         global enable / synchronous clear
//   i_valid             sample qualifier for this channel
//   i_a, i_b, i_mask    operands and shared compare mask (1 = compare)
//   o_match             result of the last valid sample
//   o_mismatch_pulse    high for one cycle after a valid mismatching sample
//   o_pass_cnt/o_fail_cnt  saturating counters
//   o_alarm             sticky alarm (FSM in ALARM)
//   o_fail_now          combinational strobe: valid mismatch on this edge
// ---------------------------------------------------------------------------
module eq_chan_checker
    import eq_mon_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_mask,
    output logic             o_match,
    output logic             o_mismatch_pulse,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_alarm,
    output logic             o_fail_now
);

    localparam logic [31:0]         CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [STREAK_W-1:0] THR     = STREAK_W'(THRESH);

    chk_state_t          r_state, w_state_nx;
    logic [STREAK_W-1:0] r_streak, w_streak_nx;
    logic                r_match, r_pulse;
    logic [CNT_W-1:0]    r_pass, r_fail;
    logic                w_sample, w_mis;

    // clr discards any coincident sample
    assign w_sample   = i_en & i_valid & ~i_clr;
    assign w_mis      = |((i_a ^ i_b) & i_mask);
    assign o_fail_now = w_sample & w_mis;

    always_comb begin
        w_state_nx  = r_state;
        w_streak_nx = r_streak;
        if (w_sample) begin
            case (r_state)
                OK: begin
                    if (w_mis) begin
                        w_streak_nx = STREAK_W'(1);
                        w_state_nx  = (THR == STREAK_W'(1)) ? ALARM : WARN;
                    end
                end
                WARN: begin
                    if (w_mis) begin
                        w_streak_nx = r_streak + STREAK_W'(1);
                        if (w_streak_nx == THR) w_state_nx = ALARM;
                    end else begin
                        w_streak_nx = '0;
                        w_state_nx  = OK;
                    end
                end
                ALARM: ;
                default: begin
                    w_streak_nx = '0;
                    w_state_nx  = OK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= OK;
            r_streak <= '0;
        end else if (i_clr) begin
            r_state  <= OK;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_streak <= w_streak_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
            r_pulse <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
        end else if (i_clr) begin
            r_match <= 1'b0;
            r_pulse <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
        end else begin
            // pulse is rewritten every edge so it drops even while en is low
            r_pulse <= w_sample & w_mis;
            if (w_sample) begin
                r_match <= ~w_mis;
                if (w_mis) r_fail <= CNT_W'(sat_inc(32'(r_fail), CNT_MAX));
                else       r_pass <= CNT_W'(sat_inc(32'(r_pass), CNT_MAX));
            end
        end
    end

    assign o_match          = r_match;
    assign o_mismatch_pulse = r_pulse;
    assign o_pass_cnt       = r_pass;
    assign o_fail_cnt       = r_fail;
    assign o_alarm          = (r_state == ALARM);

endmodule

// File: rtl/eq_compare_monitor.sv
// ---------------------------------------------------------------------------
// eq_compare_monitor
// Multi-channel registered equality monitor. One eq_chan_checker per
// channel; this level owns the sample-cycle counter and the first-failure
// capture (lowest channel index wins on a tie).
// Ports:
//   clk, rst_n, en, clr    clock, async active-low reset, enable, sync clear
//   ch_valid[NCH]          per-channel sample qualifier
//   a, b [NCH*WIDTH]       operands, channel i at [i*WIDTH +: WIDTH]
//   cmp_mask[WIDTH]        shared compare mask, 1 = compare
//   match, mismatch_pulse, alarm [NCH]   per-channel status
//   pass_cnt, fail_cnt [NCH*CNT_W]       per-channel saturating counters
//   ff_valid, ff_ch, ff_a, ff_b, ff_cycle  first-failure capture
// ---------------------------------------------------------------------------
module eq_compare_monitor
    import eq_mon_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned THRESH = 3,
    parameter int unsigned CYC_W  = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic                                    clr,
    input  logic [NCH-1:0]                          ch_valid,
    input  logic [NCH*WIDTH-1:0]                    a,
    input  logic [NCH*WIDTH-1:0]                    b,
    input  logic [WIDTH-1:0]                        cmp_mask,
    output logic [NCH-1:0]                          match,
    output logic [NCH-1:0]                          mismatch_pulse,
    output logic [NCH*CNT_W-1:0]                    pass_cnt,
    output logic [NCH*CNT_W-1:0]                    fail_cnt,
    output logic [NCH-1:0]                          alarm,
    output logic                                    ff_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ff_ch,
    output logic [WIDTH-1:0]                        ff_a,
    output logic [WIDTH-1:0]                        ff_b,
    output logic [CYC_W-1:0]                        ff_cycle
);

    localparam int unsigned FFW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   w_fail_now;
    logic             w_any;
    logic [FFW-1:0]   w_sel;
    logic [WIDTH-1:0] w_sel_a, w_sel_b;

    logic [CYC_W-1:0] r_cyc;
    logic             r_ff_valid;
    logic [FFW-1:0]   r_ff_ch;
    logic [WIDTH-1:0] r_ff_a, r_ff_b;
    logic [CYC_W-1:0] r_ff_cycle;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        eq_chan_checker #(
            .WIDTH  (WIDTH),
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_chk (
            .clk              (clk),
            .rst_n            (rst_n),
            .i_en             (en),
            .i_clr            (clr),
            .i_valid          (ch_valid[i]),
            .i_a              (a[i*WIDTH +: WIDTH]),
            .i_b              (b[i*WIDTH +: WIDTH]),
            .i_mask           (cmp_mask),
            .o_match          (match[i]),
            .o_mismatch_pulse (mismatch_pulse[i]),
            .o_pass_cnt       (pass_cnt[i*CNT_W +: CNT_W]),
            .o_fail_cnt       (fail_cnt[i*CNT_W +: CNT_W]),
            .o_alarm          (alarm[i]),
            .o_fail_now       (w_fail_now[i])
        );
    end

    // Lowest failing index wins; operands are muxed here with constant
    // slices so no variable part-select is needed downstream.
    always_comb begin
        w_any   = 1'b0;
        w_sel   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_fail_now[i] && !w_any) begin
                w_any   = 1'b1;
                w_sel   = FFW'(i);
                w_sel_a = a[i*WIDTH +: WIDTH];
                w_sel_b = b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cyc <= '0;
        else if (clr)    r_cyc <= '0;
        else if (en)     r_cyc <= r_cyc + CYC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_valid <= 1'b0;
            r_ff_ch    <= '0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cycle <= '0;
        end else if (clr) begin
            r_ff_valid <= 1'b0;
            r_ff_ch    <= '0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cycle <= '0;
        end else if (!r_ff_valid && w_any) begin
            r_ff_valid <= 1'b1;
            r_ff_ch    <= w_sel;
            r_ff_a     <= w_sel_a;
            r_ff_b     <= w_sel_b;
            r_ff_cycle <= r_cyc;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_ch    = r_ff_ch;
    assign ff_a     = r_ff_a;
    assign ff_b     = r_ff_b;
    assign ff_cycle = r_ff_cycle;

endmodule

// File: tb/tb_eq_compare_monitor.sv
// ---------------------------------------------------------------------------
// tb_eq_compare_monitor
// Directed vector table for a 4-channel monitor (CNT_W=4, THRESH=3) plus
// hand-written sequences for saturation, async reset mid-streak, and a
// 1-channel THRESH=1 instance with an all-zero mask.
// ---------------------------------------------------------------------------
module tb_eq_compare_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr;
    logic [3:0]  ch_valid;
    logic [31:0] a, b;
    logic [7:0]  cmp_mask;
    logic [3:0]  match, mismatch_pulse, alarm;
    logic [15:0] pass_cnt, fail_cnt;
    logic        ff_valid;
    logic [1:0]  ff_ch;
    logic [7:0]  ff_a, ff_b;
    logic [31:0] ff_cycle;

    logic        en1;
    logic [0:0]  ch_valid1;
    logic [7:0]  a1, b1, mask1;
    logic [0:0]  match1, pulse1, alarm1;
    logic [15:0] pass1, fail1;
    logic        ffv1;
    logic [0:0]  ffch1;
    logic [7:0]  ffa1, ffb1;
    logic [31:0] ffcyc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eq_compare_monitor #(
        .WIDTH(8), .NCH(4), .CNT_W(4), .THRESH(3), .CYC_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ch_valid(ch_valid),
        .a(a), .b(b), .cmp_mask(cmp_mask), .match(match),
        .mismatch_pulse(mismatch_pulse), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .alarm(alarm), .ff_valid(ff_valid),
        .ff_ch(ff_ch), .ff_a(ff_a), .ff_b(ff_b), .ff_cycle(ff_cycle)
    );

    eq_compare_monitor #(
        .WIDTH(8), .NCH(1), .CNT_W(16), .THRESH(1), .CYC_W(32)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .clr(1'b0), .ch_valid(ch_valid1),
        .a(a1), .b(b1), .cmp_mask(mask1), .match(match1),
        .mismatch_pulse(pulse1), .pass_cnt(pass1),
        .fail_cnt(fail1), .alarm(alarm1), .ff_valid(ffv1),
        .ff_ch(ffch1), .ff_a(ffa1), .ff_b(ffb1), .ff_cycle(ffcyc1)
    );

    typedef struct {
        logic        en, clr;
        logic [3:0]  valid;
        logic [31:0] a, b;
        logic [7:0]  mask;
        logic [3:0]  m, p, al;
        logic [3:0]  pass0, fail0;
        logic        ffv;
        logic [1:0]  ffch;
        logic [7:0]  ffa, ffb;
        logic [31:0] ffcyc;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(
        input logic en_i, input logic clr_i, input logic [3:0] v,
        input logic [31:0] ai, input logic [31:0] bi, input logic [7:0] mk_i,
        input logic [3:0] m, input logic [3:0] p, input logic [3:0] al,
        input logic [3:0] ps, input logic [3:0] fl, input logic fv,
        input logic [1:0] fc, input logic [7:0] fa, input logic [7:0] fb,
        input logic [31:0] fy);
        vec_t r;
        r.en = en_i; r.clr = clr_i; r.valid = v; r.a = ai; r.b = bi;
        r.mask = mk_i; r.m = m; r.p = p; r.al = al; r.pass0 = ps;
        r.fail0 = fl; r.ffv = fv; r.ffch = fc; r.ffa = fa; r.ffb = fb;
        r.ffcyc = fy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic [3:0] v,
                         input logic [31:0] ai, input logic [31:0] bi,
                         input logic [7:0] m);
        en = e; clr = c; ch_valid = v; a = ai; b = bi; cmp_mask = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // columns: en clr valid a b mask | match pulse alarm pass0 fail0 ffv ffch ffa ffb ffcyc
        tbl[0]  = mk(1,0,4'h1,32'h00,32'h00,8'hFF, 4'h1,4'h0,4'h0, 1,0, 0,0,8'h00,8'h00,0);
        tbl[1]  = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 1,1, 1,0,8'h01,8'h00,1);
        tbl[2]  = mk(1,0,4'h1,32'h00,32'h01,8'hFF, 4'h0,4'h1,4'h0, 1,2, 1,0,8'h01,8'h00,1);
        tbl[3]  = mk(1,0,4'h1,32'h00,32'h01,8'hFF, 4'h0,4'h1,4'h1, 1,3, 1,0,8'h01,8'h00,1);
        tbl[4]  = mk(1,0,4'h1,32'h00,32'h00,8'hFF, 4'h1,4'h0,4'h1, 2,3, 1,0,8'h01,8'h00,1);
        tbl[5]  = mk(1,1,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,0, 0,0,8'h00,8'h00,0);
        tbl[6]  = mk(1,0,4'h1,32'hF0,32'hF3,8'hF0, 4'h1,4'h0,4'h0, 1,0, 0,0,8'h00,8'h00,0);
        tbl[7]  = mk(1,0,4'h1,32'hF0,32'hF3,8'hFF, 4'h0,4'h1,4'h0, 1,1, 1,0,8'hF0,8'hF3,1);
        tbl[8]  = mk(1,0,4'h0,32'hF0,32'hF3,8'hFF, 4'h0,4'h0,4'h0, 1,1, 1,0,8'hF0,8'hF3,1);
        tbl[9]  = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 1,2, 1,0,8'hF0,8'hF3,1);
        tbl[10] = mk(1,0,4'h1,32'h00,32'h00,8'hFF, 4'h1,4'h0,4'h0, 2,2, 1,0,8'hF0,8'hF3,1);
        tbl[11] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 2,3, 1,0,8'hF0,8'hF3,1);
        tbl[12] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 2,4, 1,0,8'hF0,8'hF3,1);
        tbl[13] = mk(1,0,4'h0,32'h01,32'h00,8'hFF, 4'h0,4'h0,4'h0, 2,4, 1,0,8'hF0,8'hF3,1);
        tbl[14] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h1, 2,5, 1,0,8'hF0,8'hF3,1);
        tbl[15] = mk(1,1,4'h0,32'h00,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,0, 0,0,8'h00,8'h00,0);
        tbl[16] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 0,1, 1,0,8'h01,8'h00,0);
        tbl[17] = mk(1,0,4'h0,32'h01,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,1, 1,0,8'h01,8'h00,0);
        tbl[18] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h0, 0,2, 1,0,8'h01,8'h00,0);
        tbl[19] = mk(1,0,4'h0,32'h01,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,2, 1,0,8'h01,8'h00,0);
        tbl[20] = mk(1,0,4'h0,32'h01,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,2, 1,0,8'h01,8'h00,0);
        tbl[21] = mk(1,0,4'h1,32'h01,32'h00,8'hFF, 4'h0,4'h1,4'h1, 0,3, 1,0,8'h01,8'h00,0);
        tbl[22] = mk(1,1,4'h0,32'h00,32'h00,8'hFF, 4'h0,4'h0,4'h0, 0,0, 0,0,8'h00,8'h00,0);
        tbl[23] = mk(1,0,4'h7,32'h00331100,32'h00442200,8'hFF, 4'h1,4'h6,4'h0, 1,0, 1,1,8'h11,8'h22,0);
        tbl[24] = mk(1,0,4'h1,32'h00331155,32'h00442266,8'hFF, 4'h0,4'h1,4'h0, 1,1, 1,1,8'h11,8'h22,0);
        tbl[25] = mk(0,0,4'h1,32'h00331155,32'h00442266,8'hFF, 4'h0,4'h0,4'h0, 1,1, 1,1,8'h11,8'h22,0);

        rst_n = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 8'hFF);
        en1 = 1'b0; ch_valid1 = 1'b0; a1 = 8'h00; b1 = 8'h00; mask1 = 8'h00;
        #12;
        chk("reset match", {28'h0, match}, 32'h0);
        chk("reset pass_cnt", {16'h0, pass_cnt}, 32'h0);
        chk("reset fail_cnt", {16'h0, fail_cnt}, 32'h0);
        chk("reset alarm", {28'h0, alarm}, 32'h0);
        chk("reset ff_valid", {31'h0, ff_valid}, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].mask);
            step();
            chk($sformatf("v%0d match", i), {28'h0, match}, {28'h0, tbl[i].m});
            chk($sformatf("v%0d pulse", i), {28'h0, mismatch_pulse}, {28'h0, tbl[i].p});
            chk($sformatf("v%0d alarm", i), {28'h0, alarm}, {28'h0, tbl[i].al});
            chk($sformatf("v%0d pass0", i), {28'h0, pass_cnt[3:0]}, {28'h0, tbl[i].pass0});
            chk($sformatf("v%0d fail0", i), {28'h0, fail_cnt[3:0]}, {28'h0, tbl[i].fail0});
            chk($sformatf("v%0d ff_valid", i), {31'h0, ff_valid}, {31'h0, tbl[i].ffv});
            chk($sformatf("v%0d ff_ch", i), {30'h0, ff_ch}, {30'h0, tbl[i].ffch});
            chk($sformatf("v%0d ff_a", i), {24'h0, ff_a}, {24'h0, tbl[i].ffa});
            chk($sformatf("v%0d ff_b", i), {24'h0, ff_b}, {24'h0, tbl[i].ffb});
            chk($sformatf("v%0d ff_cycle", i), ff_cycle, tbl[i].ffcyc);
        end

        // Saturation: 20 mismatches on a 4-bit counter stop at 15.
        drive(1, 1, 4'h0, 32'h0, 32'h0, 8'hFF);
        step();
        for (int i = 1; i <= 20; i++) begin
            drive(1, 0, 4'h1, 32'h01, 32'h00, 8'hFF);
            step();
            chk($sformatf("sat fail0 #%0d", i), {28'h0, fail_cnt[3:0]},
                (i > 15) ? 32'd15 : 32'(i));
        end
        chk("sat pass0", {28'h0, pass_cnt[3:0]}, 32'h0);
        chk("sat alarm0", {31'h0, alarm[0]}, 32'h1);
        drive(1, 1, 4'h1, 32'h01, 32'h00, 8'hFF);
        step();
        chk("clr+sample fail0", {28'h0, fail_cnt[3:0]}, 32'h0);
        chk("clr+sample pulse", {28'h0, mismatch_pulse}, 32'h0);
        chk("clr+sample alarm", {28'h0, alarm}, 32'h0);
        chk("clr+sample ff_valid", {31'h0, ff_valid}, 32'h0);

        // Async reset while in WARN with nonzero counters.
        drive(1, 0, 4'h1, 32'h00, 32'h00, 8'hFF);
        step();
        drive(1, 0, 4'h1, 32'h01, 32'h00, 8'hFF);
        step();
        chk("pre-rst fail0", {28'h0, fail_cnt[3:0]}, 32'h1);
        chk("pre-rst pass0", {28'h0, pass_cnt[3:0]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst pass_cnt", {16'h0, pass_cnt}, 32'h0);
        chk("async rst fail_cnt", {16'h0, fail_cnt}, 32'h0);
        chk("async rst pulse", {28'h0, mismatch_pulse}, 32'h0);
        chk("async rst ff_valid", {31'h0, ff_valid}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("post-rst fail0", {28'h0, fail_cnt[3:0]}, 32'h1);
        chk("post-rst ff_cycle", ff_cycle, 32'h0);
        chk("post-rst ff_a", {24'h0, ff_a}, 32'h01);
        step();
        chk("post-rst 2nd alarm", {31'h0, alarm[0]}, 32'h0);
        step();
        chk("post-rst 3rd alarm", {31'h0, alarm[0]}, 32'h1);

        // THRESH=1 instance, all-zero mask matches everything.
        en1 = 1'b1; ch_valid1 = 1'b1; a1 = 8'hAA; b1 = 8'h55; mask1 = 8'h00;
        step();
        chk("t1 zero-mask match", {31'h0, match1}, 32'h1);
        chk("t1 zero-mask alarm", {31'h0, alarm1}, 32'h0);
        mask1 = 8'hFF;
        step();
        chk("t1 match", {31'h0, match1}, 32'h0);
        chk("t1 pulse", {31'h0, pulse1}, 32'h1);
        chk("t1 alarm", {31'h0, alarm1}, 32'h1);
        chk("t1 ff_a", {24'h0, ffa1}, 32'hAA);
        chk("t1 ff_cycle", ffcyc1, 32'h1);
        chk("t1 pass/fail", {pass1, fail1}, {16'd1, 16'd1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
